// File: rtl/register_file.sv
// register_file: 32-entry architectural register file with per-register busy bit and ROB rename tag.
// Define RF_BYPASS_EN to forward a same-cycle matching commit onto the read ports.
module register_file #(
  parameter int XLEN      = 32,
  parameter int ROB_IDX_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 flush,
  input  logic                 issue_valid,
  input  logic [4:0]           issue_rd,
  input  logic [ROB_IDX_W-1:0] issue_rob_index,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  output logic                 rs1_busy,
  output logic [ROB_IDX_W-1:0] rs1_tag,
  output logic [XLEN-1:0]      rs1_value,
  output logic                 rs2_busy,
  output logic [ROB_IDX_W-1:0] rs2_tag,
  output logic [XLEN-1:0]      rs2_value,
  input  logic                 rf_valid,
  input  logic [ROB_IDX_W-1:0] rf_index,
  input  logic [4:0]           rf_rd,
  input  logic [XLEN-1:0]      rf_value
);
  logic [XLEN-1:0]      r_value [32];
  logic [31:0]          r_busy;
  logic [ROB_IDX_W-1:0] r_tag [32];
  logic w_issue, w_commit, w_clear, w_byp1, w_byp2;
  assign w_issue  = rdy & issue_valid & ~flush & (issue_rd != 5'd0);
  assign w_commit = rdy & rf_valid & (rf_rd != 5'd0);
  // A commit only releases the register if it is still the newest producer and no new claim lands now
  assign w_clear  = w_commit & ~flush & r_busy[rf_rd] & (r_tag[rf_rd] == rf_index) &
                    ~(w_issue & (issue_rd == rf_rd));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
      for (int i = 0; i < 32; i++) begin
        r_value[i] <= '0;
        r_tag[i]   <= '0;
      end
    end else begin
      if (w_commit) r_value[rf_rd] <= rf_value;
      if (flush) begin
        r_busy <= '0;
        for (int i = 0; i < 32; i++) r_tag[i] <= '0;
      end else if (w_issue) begin
        r_busy[issue_rd] <= 1'b1;
        r_tag[issue_rd]  <= issue_rob_index;
      end
      if (w_clear) r_busy[rf_rd] <= 1'b0;
    end
  end
`ifdef RF_BYPASS_EN
  assign w_byp1 = w_commit & (rf_rd == rs1) & r_busy[rs1] & (r_tag[rs1] == rf_index);
  assign w_byp2 = w_commit & (rf_rd == rs2) & r_busy[rs2] & (r_tag[rs2] == rf_index);
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif
  assign rs1_busy  = (rs1 != 5'd0) & r_busy[rs1] & ~w_byp1;
  assign rs1_tag   = rs1_busy ? r_tag[rs1] : '0;
  assign rs1_value = (rs1 == 5'd0 || rs1_busy) ? '0 : w_byp1 ? rf_value : r_value[rs1];
  assign rs2_busy  = (rs2 != 5'd0) & r_busy[rs2] & ~w_byp2;
  assign rs2_tag   = rs2_busy ? r_tag[rs2] : '0;
  assign rs2_value = (rs2 == 5'd0 || rs2_busy) ? '0 : w_byp2 ? rf_value : r_value[rs2];
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed stimulus with an event-level reference model checked every negedge.
module tb_register_file;
  logic clk = 0, rst = 1, rdy = 1, flush = 0, issue_valid = 0, rf_valid = 0;
  logic [4:0] issue_rd = 0, rs1 = 0, rs2 = 0, rf_rd = 0;
  logic [5:0] issue_rob_index = 0, rf_index = 0;
  logic [31:0] rf_value = 0;
  logic rs1_busy, rs2_busy;
  logic [5:0] rs1_tag, rs2_tag;
  logic [31:0] rs1_value, rs2_value;
  int total = 0, bad = 0;
  logic [31:0] m_val [32];
  logic m_busy [32];
  logic [5:0] m_tag [32];

  register_file dut (.clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .issue_rob_index(issue_rob_index), .rs1(rs1), .rs2(rs2),
    .rs1_busy(rs1_busy), .rs1_tag(rs1_tag), .rs1_value(rs1_value),
    .rs2_busy(rs2_busy), .rs2_tag(rs2_tag), .rs2_value(rs2_value),
    .rf_valid(rf_valid), .rf_index(rf_index), .rf_rd(rf_rd), .rf_value(rf_value));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Events are applied in increasing priority: commit, then issue, then flush overrides.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin m_val[i] = 0; m_busy[i] = 0; m_tag[i] = 0; end
    end else begin
      if (rdy && rf_valid && rf_rd != 0) begin
        m_val[rf_rd] = rf_value;
        if (m_busy[rf_rd] && m_tag[rf_rd] == rf_index) m_busy[rf_rd] = 0;
      end
      if (rdy && issue_valid && issue_rd != 0) begin m_busy[issue_rd] = 1; m_tag[issue_rd] = issue_rob_index; end
      if (flush) for (int i = 0; i < 32; i++) begin m_busy[i] = 0; m_tag[i] = 0; end
    end
  end

  task automatic cmp_port(input string p, input logic [4:0] r, input logic b, input logic [5:0] t, input logic [31:0] v);
    logic byp, eb;
    byp = 0;
`ifdef RF_BYPASS_EN
    byp = rdy && rf_valid && rf_rd != 0 && rf_rd == r && m_busy[r] && m_tag[r] == rf_index;
`endif
    eb = (r != 0) && m_busy[r] && !byp;
    chk({p, "_busy"}, {31'd0, b}, {31'd0, eb});
    chk({p, "_tag"}, {26'd0, t}, eb ? {26'd0, m_tag[r]} : 32'd0);
    chk({p, "_value"}, v, (r == 0 || eb) ? 32'd0 : byp ? rf_value : m_val[r]);
  endtask

  always @(negedge clk) begin
    cmp_port("rs1", rs1, rs1_busy, rs1_tag, rs1_value);
    cmp_port("rs2", rs2, rs2_busy, rs2_tag, rs2_value);
  end

  task automatic cyc();
    @(posedge clk); #1;
    issue_valid = 0; rf_valid = 0; flush = 0; rdy = 1;
  endtask
  task automatic iss(input logic [4:0] rd, input logic [5:0] idx);
    issue_valid = 1; issue_rd = rd; issue_rob_index = idx;
  endtask
  task automatic com(input logic [5:0] idx, input logic [4:0] rd, input logic [31:0] v);
    rf_valid = 1; rf_index = idx; rf_rd = rd; rf_value = v;
  endtask

  initial begin
    rs1 = 5; rs2 = 0;
    repeat (2) @(posedge clk); #1;
    chk("rst_rs1_busy", {31'd0, rs1_busy}, 0);
    chk("rst_rs1_value", rs1_value, 0);
    chk("rst_rs2_tag", {26'd0, rs2_tag}, 0);
    rst = 0;
    iss(3, 12); cyc();
    rs1 = 3; #1;
    chk("x3_busy", {31'd0, rs1_busy}, 1);
    chk("x3_tag", {26'd0, rs1_tag}, 12);
    com(12, 3, 32'hDEADBEEF); #1;
`ifdef RF_BYPASS_EN
    chk("x3_byp_busy", {31'd0, rs1_busy}, 0);
    chk("x3_byp_value", rs1_value, 32'hDEADBEEF);
`else
    chk("x3_nobyp_busy", {31'd0, rs1_busy}, 1);
`endif
    cyc();
    chk("x3_done_busy", {31'd0, rs1_busy}, 0);
    chk("x3_done_value", rs1_value, 32'hDEADBEEF);
    iss(7, 4); cyc();
    iss(7, 9); cyc();
    com(4, 7, 32'h11); cyc();
    rs1 = 7; #1;
    chk("x7_stale_busy", {31'd0, rs1_busy}, 1);
    chk("x7_stale_tag", {26'd0, rs1_tag}, 9);
    chk("x7_stale_model", m_val[7], 32'h11);
    com(9, 7, 32'h22); cyc();
    chk("x7_done_value", rs1_value, 32'h22);
    iss(8, 15); cyc();
    iss(8, 20); com(15, 8, 32'h55); cyc();
    rs1 = 8; #1;
    chk("x8_busy", {31'd0, rs1_busy}, 1);
    chk("x8_tag", {26'd0, rs1_tag}, 20);
    iss(1, 1); cyc();
    iss(2, 2); cyc();
    iss(4, 3); cyc();
    rs1 = 2; rs2 = 4; #1;
    chk("x2_pre_busy", {31'd0, rs1_busy}, 1);
    flush = 1; com(1, 1, 32'hAA); iss(5, 7); cyc();
    chk("x2_flush_busy", {31'd0, rs1_busy}, 0);
    chk("x4_flush_value", rs2_value, 0);
    rs1 = 1; rs2 = 5; #1;
    chk("x1_flush_value", rs1_value, 32'hAA);
    chk("x5_flush_busy", {31'd0, rs2_busy}, 0);
    rs1 = 8; #1;
    chk("x8_flush_value", rs1_value, 32'h55);
    iss(0, 3); com(3, 0, 32'h1234); cyc();
    rs1 = 0; #1;
    chk("x0_busy", {31'd0, rs1_busy}, 0);
    chk("x0_value", rs1_value, 0);
    rdy = 0; iss(6, 5); com(5, 6, 32'h99); cyc();
    rs1 = 6; rs2 = 3; #1;
    chk("x6_rdy0_busy", {31'd0, rs1_busy}, 0);
    chk("x6_rdy0_value", rs1_value, 0);
    iss(6, 33); cyc();
    chk("x6_busy", {31'd0, rs1_busy}, 1);
    #1 rst = 1; #1;
    chk("arst_x6_busy", {31'd0, rs1_busy}, 0);
    chk("arst_x6_tag", {26'd0, rs1_tag}, 0);
    chk("arst_x3_value", rs2_value, 0);
    @(posedge clk); #2 rst = 0;
    iss(9, 40); cyc();
    rs1 = 9; rs2 = 9; #1;
    chk("x9_tag", {26'd0, rs2_tag}, 40);
    repeat (2) @(posedge clk);
    #1 $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Architectural integer register file with rename tags. Sits downstream of the ROB commit port and alongside the issue unit.
- Holds 32 architectural values. Per register it also records whether an in-flight ROB entry will produce it, and which one (a busy bit plus a 6-bit ROB tag).
- The issue unit reads operands as either a ready value or a ROB tag, and claims the destination register of each issued instruction.
- Commits from the ROB write values in program order. Flush discards all renames.

Parameters:
- XLEN, 32, data width of each register.
- ROB_IDX_W, 6, width of a ROB index / rename tag (64-entry ROB).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- rdy  input  1  global ready; when low, commit and issue updates are ignored (flush still acts).
- flush  input  1  misprediction flush from ROB; clears all busy bits.
- issue_valid  input  1  an instruction is issued this cycle.
- issue_rd  input  5  destination of the issued instruction.
- issue_rob_index  input  ROB_IDX_W  ROB entry allocated to the issued instruction.
- rs1  input  5  source register 1 index.
- rs2  input  5  source register 2 index.
- rs1_busy  output  1  rs1 awaits an in-flight producer.
- rs1_tag  output  ROB_IDX_W  producer ROB index when rs1_busy, else 0.
- rs1_value  output  XLEN  register value when !rs1_busy, else 0.
- rs2_busy, rs2_tag, rs2_value  output  1/ROB_IDX_W/XLEN  same for rs2.
- rf_valid  input  1  ROB commit strobe.
- rf_index  input  ROB_IDX_W  ROB index of the committing entry.
- rf_rd  input  5  committing destination register.
- rf_value  input  XLEN  committing result.

Behaviour:
- State: value[0..31] (XLEN), busy[0..31], tag[0..31] (ROB_IDX_W).
- Reset (async, rst=1): all values 0, busy 0, tag 0. Read outputs are combinational, so with reset asserted they read busy=0, tag=0, value=0.
- Read ports are combinational, with zero latency:
  - Index 0 always returns busy=0, tag=0, value=0.
  - Otherwise they return busy[r], tag[r] (forced to 0 if not busy), and value[r] (forced to 0 if busy).
- Reads never observe a same-cycle issue. An instruction's own rd never affects its sources, including when rd == rs1 or rd == rs2.
- Commit, on a rising edge with rdy=1 and rf_valid=1 and rf_rd != 0:
  - value[rf_rd] <= rf_value, unconditionally.
  - busy[rf_rd] is cleared only if busy[rf_rd]=1 and tag[rf_rd]==rf_index, and no issue to the same rd occurs this cycle.
  - A stale tag (a newer producer exists) updates the value but leaves busy and tag untouched.
- Issue, on a rising edge with rdy=1, issue_valid=1 and issue_rd != 0: busy[issue_rd] <= 1, tag[issue_rd] <= issue_rob_index.
- Issue and commit to the same rd in the same cycle: the value is written, busy stays 1, and tag takes issue_rob_index.
- Writes to x0 (commit or issue) are ignored entirely.
- Flush, on a rising edge with flush=1, independent of rdy:
  - All busy bits clear and all tags go to 0.
  - Issue in the same cycle is ignored.
  - Commit in the same cycle with rdy=1 still writes its value; the ROB commits the mispredicting head together with flush.
- rdy=0 with flush=0: no state changes; reads remain live.
- Priority per register per edge: reset > flush (busy/tag) > issue (busy/tag) > commit (busy clear). The value write is governed by commit only.
- Tag reuse: the ROB wraps its 64 entries. A matching tag on commit is taken as the owning producer; the ROB guarantees no older alias is outstanding.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: when a commit with rdy=1, rf_valid=1, rf_rd==rsX (nonzero), busy[rsX]=1 and tag[rsX]==rf_index occurs in the same cycle as a read, the read returns busy=0, tag=0, value=rf_value. The same-cycle issue exclusion still applies.
- Undefined: reads reflect only registered state, so the committed value becomes visible on the next cycle.

Test Plan:
- Reset then read rs1=5, rs2=0 -> busy=0, tag=0, value=0 on both ports.
- Issue rd=3 with rob=12; next cycle read rs1=3 -> busy=1, tag=12. Then commit index=12, rd=3, value=0xDEADBEEF; next cycle -> busy=0, value=0xDEADBEEF. With RF_BYPASS_EN, a read in the commit cycle already shows busy=0, value=0xDEADBEEF.
- Issue rd=7 rob=4, then issue rd=7 rob=9; commit idx=4 rd=7 value=0x11 -> value=0x11 stored, read shows busy=1, tag=9. Commit idx=9 value=0x22 -> busy=0, value=0x22.
- Same cycle: issue rd=8 rob=20 and commit idx=15 rd=8 value=0x55 (tag was 15) -> busy=1, tag=20, value[8]=0x55.
- Issue rd=1,2,4 (rob 1,2,3), then flush together with commit idx=1 rd=1 value=0xAA -> all busy=0; x1=0xAA, x2 and x4 keep their prior values. An issue rd=5 in the same flush cycle leaves x5 not busy.
- Issue/commit to rd=0 with value 0x1234 -> x0 reads busy=0, value=0. With rdy=0, issue rd=6 and commit rd=6 -> no change. Async rst asserted mid-cycle -> values zeroed and busy/tag outputs read 0 immediately, without waiting for an edge.
